// File: rtl/tff_ctr_pkg.sv
// Shared types and helpers for the T-flip-flop up/down counter.
// Mode encoding and the JK-to-T conversion used by the parallel-load path.
package tff_ctr_pkg;

   typedef enum logic [1:0] {
      CTR_HOLD = 2'b00,
      CTR_LOAD = 2'b01,
      CTR_UP   = 2'b10,
      CTR_DOWN = 2'b11
   } ctr_mode_e;

   // Load has priority over count; count enable over hold.
   function automatic ctr_mode_e decode_mode(input logic load, input logic en, input logic up);
      if (load) begin
         return CTR_LOAD;
      end else if (en) begin
         return up ? CTR_UP : CTR_DOWN;
      end else begin
         return CTR_HOLD;
      end
   endfunction

   function automatic logic jk_to_t(input logic j, input logic k, input logic q);
      return (j & ~q) | (k & q);
   endfunction

endpackage

// File: rtl/t_ff.sv
// Single T flip-flop with asynchronous active-low preset and clear.
// Clear dominates preset when both are asserted.
module t_ff (
   input  logic T,
   input  logic clk,
   input  logic pre_bar,
   input  logic clr_bar,
   output logic Q,
   output logic Qbar
);

   always_ff @(posedge clk or negedge clr_bar or negedge pre_bar) begin
      if (!clr_bar) begin
         Q <= 1'b0;
      end else if (!pre_bar) begin
         Q <= 1'b1;
      end else begin
         Q <= Q ^ T;
      end
   end

   assign Qbar = ~Q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter built from a bank of T flip-flops.
// Define TFF_CTR_SAT_EN to saturate at the range ends instead of wrapping.
module tff_updown_counter
   import tff_ctr_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             clr_bar,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] TopVal = WIDTH'(MODULUS - 1);

   ctr_mode_e        mode;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q_bar;
   logic             at_top;
   logic             at_zero;

   assign mode    = decode_mode(load, en, up);
   // Out-of-range values also count as "at top" so an up count recovers into range.
   assign at_top  = (q >= TopVal);
   assign at_zero = &q_bar;

   always_comb begin
      nxt = q;
      case (mode)
         CTR_LOAD: nxt = d;
`ifdef TFF_CTR_SAT_EN
         CTR_UP:   nxt = at_top ? q : q + WIDTH'(1);
         CTR_DOWN: nxt = at_zero ? q : q - WIDTH'(1);
`else
         CTR_UP:   nxt = at_top ? '0 : q + WIDTH'(1);
         CTR_DOWN: nxt = at_zero ? TopVal : q - WIDTH'(1);
`endif
         default:  nxt = q;
      endcase
   end

   always_comb begin
      t = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (mode == CTR_LOAD) begin
            t[i] = jk_to_t(d[i], ~d[i], q[i]);
         end else begin
            t[i] = q[i] ^ nxt[i];
         end
      end
   end

   assign tc = ((mode == CTR_UP) & at_top) | ((mode == CTR_DOWN) & at_zero);

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      t_ff u_t_ff (
         .T       (t[i]),
         .clk     (clk),
         .pre_bar (1'b1),
         .clr_bar (clr_bar),
         .Q       (q[i]),
         .Qbar    (q_bar[i])
      );
   end

endmodule
